// File: rtl/prio_arb_rr_if.sv
// prio_arb_rr_if: bundle of request/grant signals between requesters and the
// priority/round-robin arbiter.
//   en        : arbitration enable (requester side -> arbiter)
//   mode      : 0 = fixed MSB-first, 1 = round-robin
//   req[N]    : request vector, bit i = requester i
//   done      : grantee releases the resource
//   gnt[N]    : one-hot registered grant (arbiter -> requester side)
//   gnt_idx   : binary index of the grantee
//   gnt_valid : grant active
//   gnt_cnt   : saturating count of grants issued
// Modport master = requester side, slave = arbiter.
interface prio_arb_rr_if #(
  parameter int N    = 8,
  parameter int IDXW = 3,
  parameter int CW   = 16
);
  logic            en;
  logic            mode;
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic [CW-1:0]   gnt_cnt;

  modport master (
    output en, mode, req, done,
    input  gnt, gnt_idx, gnt_valid, gnt_cnt
  );

  modport slave (
    input  en, mode, req, done,
    output gnt, gnt_idx, gnt_valid, gnt_cnt
  );
endinterface

// File: rtl/prio_arb_rr.sv
// prio_arb_rr: registered N-way arbiter with fixed MSB-first or round-robin
// selection. A grant is locked until the grantee raises done or drops its
// request; a release always leaves at least one idle cycle before the next
// grant. Every output comes straight from a flop.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : prio_arb_rr_if.slave (en, mode, req, done in; gnt, gnt_idx,
//           gnt_valid, gnt_cnt out)
module prio_arb_rr #(
  parameter int N    = 8,
  parameter int IDXW = 3,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  prio_arb_rr_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]      state_q,     state_d;
  logic [N-1:0]    gnt_q,       gnt_d;
  logic [IDXW-1:0] gnt_idx_q,   gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [CW-1:0]   gnt_cnt_q,   gnt_cnt_d;
  logic [IDXW-1:0] ptr_q,       ptr_d;

  logic [IDXW-1:0] hi_all_s;   // highest set request index
  logic [IDXW-1:0] hi_le_s;    // highest set request index <= ptr
  logic            any_le_s;   // some request at or below ptr
  logic [IDXW-1:0] win_s;
  logic            release_s;

  // Highest-set-bit searches: overall, and restricted to indices <= ptr.
  // A descending round-robin scan from ptr with wrap picks the highest set
  // bit <= ptr if one exists, otherwise the highest set bit overall.
  always_comb begin
    hi_all_s = '0;
    hi_le_s  = '0;
    any_le_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) begin
        hi_all_s = IDXW'(i);
        if (IDXW'(i) <= ptr_q) begin
          hi_le_s  = IDXW'(i);
          any_le_s = 1'b1;
        end else begin
          any_le_s = any_le_s;
        end
      end else begin
        hi_all_s = hi_all_s;
      end
    end
  end

  assign win_s = (bus.mode && any_le_s) ? hi_le_s : hi_all_s;

  // Release when the grantee signals done or its own request bit drops;
  // both together still form one release.
  assign release_s = bus.done || ((bus.req & gnt_q) == '0);

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    gnt_cnt_d   = gnt_cnt_q;
    ptr_d       = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && (bus.req != '0)) begin
          state_d     = ST_BUSY;
          gnt_d       = {{(N-1){1'b0}}, 1'b1} << win_s;
          gnt_idx_d   = win_s;
          gnt_valid_d = 1'b1;
          if (gnt_cnt_q != {CW{1'b1}}) begin
            gnt_cnt_d = gnt_cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            gnt_cnt_d = gnt_cnt_q;
          end
          if (bus.mode) begin
            ptr_d = (win_s == '0) ? IDXW'(N-1) : (win_s - {{(IDXW-1){1'b0}}, 1'b1});
          end else begin
            ptr_d = ptr_q;
          end
        end else begin
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (release_s) begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      gnt_cnt_q   <= '0;
      ptr_q       <= IDXW'(N-1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_cnt_q   <= gnt_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_cnt   = gnt_cnt_q;

endmodule

// File: tb/tb_prio_arb_rr.sv
// Directed bench for prio_arb_rr with N=4, IDXW=3 (upper index bit must stay
// 0) and CW=4 so counter saturation is reachable.
module tb_prio_arb_rr;
  localparam int N    = 4;
  localparam int IDXW = 3;
  localparam int CW   = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  prio_arb_rr_if #(.N(N), .IDXW(IDXW), .CW(CW)) bus ();

  prio_arb_rr #(.N(N), .IDXW(IDXW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [3:0] g, input logic [2:0] idx,
                             input logic v, input logic [3:0] cnt);
    check({tag, ".gnt"},   32'(bus.gnt),       32'(g));
    check({tag, ".idx"},   32'(bus.gnt_idx),   32'(idx));
    check({tag, ".valid"}, 32'(bus.gnt_valid), 32'(v));
    check({tag, ".cnt"},   32'(bus.gnt_cnt),   32'(cnt));
  endtask

  initial begin
    logic [2:0] rr_exp [5];
    int g;
    rr_exp = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd3};
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.mode = 1'b0; bus.req = 4'b0000; bus.done = 1'b0;

    // Reset state, before any clock edge.
    #3;
    check_grant("reset", 4'b0000, 3'd0, 1'b0, 4'd0);
    tick();
    rst_n = 1'b1;

    // Fixed mode first grant: highest set bit of 0011.
    bus.en = 1'b1; bus.req = 4'b0011;
    tick();
    check_grant("fix1", 4'b0010, 3'd1, 1'b1, 4'd1);

    // Lock: a higher request appearing must not steal the grant.
    bus.req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_grant("lock", 4'b0010, 3'd1, 1'b1, 4'd1);
    end
    bus.done = 1'b1;
    tick();
    check_grant("rel1", 4'b0000, 3'd0, 1'b0, 4'd1);
    bus.done = 1'b0; bus.req = 4'b1001;
    tick();
    check_grant("fix2", 4'b1000, 3'd3, 1'b1, 4'd2);

    // Release by dropping the grantee's request bit.
    bus.req = 4'b0001;
    tick();
    check_grant("drop", 4'b0000, 3'd0, 1'b0, 4'd2);
    tick();
    check_grant("fix3", 4'b0001, 3'd0, 1'b1, 4'd3);

    // done together with the request drop: one release, no extra count.
    bus.done = 1'b1; bus.req = 4'b0000;
    tick();
    check_grant("both", 4'b0000, 3'd0, 1'b0, 4'd3);
    bus.done = 1'b0;
    tick();
    check_grant("noreq", 4'b0000, 3'd0, 1'b0, 4'd3);

    // Disabled arbiter ignores requests.
    bus.en = 1'b0; bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en0.valid", 32'(bus.gnt_valid), 32'd0);
    end

    // Round-robin with all requests held: 3,2,1,0,3 with bubbles.
    bus.en = 1'b1; bus.mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_grant("rr", 4'(4'b0001 << rr_exp[i]), rr_exp[i], 1'b1, 4'(4 + i));
      bus.done = 1'b1;
      if (i == 4) bus.mode = 1'b0;  // mode change while busy
      tick();
      check("rr.bubble", 32'(bus.gnt_valid), 32'd0);
      bus.done = 1'b0;
    end
    // ptr is now 2; fixed mode still picks 3 and leaves ptr alone.
    tick();
    check_grant("fixmid", 4'b1000, 3'd3, 1'b1, 4'd9);
    bus.mode = 1'b1; bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check_grant("rrkeep", 4'b0100, 3'd2, 1'b1, 4'd10);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;

    // Async reset in the middle of a grant of index 2.
    bus.mode = 1'b0; bus.req = 4'b0100;
    tick();
    check_grant("pre_rst", 4'b0100, 3'd2, 1'b1, 4'd11);
    #2 rst_n = 1'b0;
    #1;
    check_grant("async_rst", 4'b0000, 3'd0, 1'b0, 4'd0);
    tick();
    rst_n = 1'b1; bus.mode = 1'b1; bus.req = 4'b1111;

    // 17 round-robin grants: counter saturates at 15; ptr restarted at 3.
    for (g = 1; g <= 17; g++) begin
      tick();
      check_grant("sat", 4'(4'b0001 << (3 - ((g - 1) % 4))), 3'(3 - ((g - 1) % 4)), 1'b1,
                  4'((g > 15) ? 15 : g));
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    check("sat.final", 32'(bus.gnt_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prio_arb_rr.md
Name: prio_arb_rr

Overview:
- Parametrised, registered successor to the 4-bit combinational priority encoder.
- Accepts N request lines and issues a one-hot grant plus a binary index.
- Two arbitration modes:
  - fixed MSB-first, identical ordering to the existing encoder;
  - round-robin.
- A grant is held (locked) until the grantee releases it.
- Sits between lab request sources (switch/peripheral requesters) and a shared resource.

Parameters:
- N, 8, number of request lines (N >= 2).
- IDXW, 3, width of gnt_idx; must satisfy 2**IDXW >= N.
- CW, 16, width of the saturating grant counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbitration enable; sampled only in IDLE.
- mode  in  1  0 = fixed MSB-first, 1 = round-robin; sampled only in IDLE.
- req  in  N  request vector, bit i = requester i.
- done  in  1  grantee releases the resource.
- gnt  out  N  one-hot grant, registered.
- gnt_idx  out  IDXW  binary index of the grantee, registered.
- gnt_valid  out  1  grant active.
- gnt_cnt  out  CW  number of grants issued, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, ptr=N-1, gnt_cnt=0. An in-flight grant is aborted; no release cycle is produced.
- States: IDLE, BUSY.
- IDLE, at a clk edge:
  - en=1 and req!=0: winner k is chosen. Registered outputs become gnt=1<<k, gnt_idx=k, gnt_valid=1, gnt_cnt+=1 (saturating at 2**CW-1). State goes to BUSY. Latency from req to gnt is 1 cycle.
  - en=0 or req=0: remain in IDLE; outputs stay 0.
- Winner selection:
  - mode=0: highest set index wins. ptr is not modified.
  - mode=1: search starts at ptr and descends with wrap (ptr, ptr-1, ..., 0, N-1, ...); the first set bit wins. After a grant to k, ptr <= (k==0) ? N-1 : k-1.
  - Because reset ptr is N-1, the first round-robin decision after reset matches mode 0.
- BUSY:
  - gnt, gnt_idx and gnt_valid hold constant.
  - Changes on other req bits, en and mode are ignored.
- Release: in BUSY, done=1 or req[gnt_idx]=0 causes, at that edge, gnt=0, gnt_valid=0, state=IDLE.
  - done and a req drop in the same cycle produce a single release.
- Bubble: at least one gnt_valid=0 cycle always separates consecutive grants; the next grant appears at the edge after the release edge at the earliest.
- mode change in BUSY takes effect at the next IDLE decision. ptr is retained across mode switches.
- Implementation constraints:
  - Bits of req at index >= N do not exist.
  - gnt_idx upper bits beyond clog2(N) are 0.
  - All outputs are driven directly from flops, with no combinational path from req to outputs.

Test Plan:
- Reset/fixed (N=4, mode=0, en=1):
  - req=0011 -> one edge later gnt=0010, gnt_idx=1, gnt_valid=1, gnt_cnt=1.
  - Pulse done, then req=1001 -> after the bubble cycle gnt=1000, gnt_idx=3, gnt_cnt=2.
- Lock (N=4, mode=0):
  - While granted idx=1, req changes 0010->1010 -> gnt stays 0010 until done.
  - Then one bubble cycle, then gnt=1000.
- Round-robin (N=4, mode=1, req=1111 held, done pulsed once per grant):
  - gnt_idx sequence 3,2,1,0,3.
  - gnt_valid pattern 1,0,1,0,... (grant/bubble alternating).
- Idle conditions:
  - en=0 with req=1111 -> no grant for 5 cycles.
  - en=1, req=0000 -> no grant.
  - In BUSY, dropping req[gnt_idx] releases exactly as done does.
  - done together with the req drop -> a single release; gnt_cnt is unaffected.
- Async reset mid-BUSY:
  - Assert rst_n=0 between clock edges while gnt=0100 -> gnt=0, gnt_valid=0, gnt_cnt=0 immediately, without waiting for a clk edge.
  - After deassert, mode=1, req=1111 -> first grant idx=3 (ptr was reset).
- Saturation (CW=4, N=4):
  - 17 grant/release cycles -> gnt_cnt reaches 15 and stays 15.
